bomb_timer: RTL and testbench
=============================

Name: bomb_timer

Overview:
Countdown timer stage that sits directly beside the bomb control FSM.
- Consumes the FSM's countLoadN and countEnable.
- Produces the FSM's oneSecPulse and timerEnd inputs, plus two BCD digits for the seven-segment display path.
- Contains a free-running one-second prescaler and a two-digit BCD down-counter that saturates at 00.

Parameters:
CLK_FREQ_HZ, 50_000_000, clk cycles per oneSecPulse period; the bench overrides it with small values.
PRESET_TENS, 3, tens digit loaded on countLoadN; legal range 0..9.
PRESET_ONES, 0, ones digit loaded on countLoadN; legal range 0..9.
WARN_SEC, 5, warning threshold in seconds (used only with BOMB_TIMER_WARN_EN); legal range 1..99.

Ports:
clk  input  1  system clock
resetN  input  1  asynchronous reset, active-low
countLoadN  input  1  synchronous load of the preset, active-low
countEnable  input  1  permits a decrement on each oneSecPulse
oneSecPulse  output  1  one-clk-wide pulse once per CLK_FREQ_HZ cycles
timerEnd  output  1  high while the count is 00
tensDigit  output  4  BCD tens digit
onesDigit  output  4  BCD ones digit
warning  output  1  (BOMB_TIMER_WARN_EN only) final-seconds indicator

Behaviour:
Interface:
- Reset resetN is asynchronous, active-low.
- All state is clocked on the rising edge of clk.

Reset values:
- prescaler = 0, oneSecPulse = 0.
- tensDigit = PRESET_TENS, onesDigit = PRESET_ONES.
- timerEnd = (preset == 00), warning = 0.

Prescaler:
- Counter width is $clog2(CLK_FREQ_HZ).
- It counts 0..CLK_FREQ_HZ-1 and then wraps to 0.
- It is free-running: never gated by countEnable and never cleared by countLoadN.
- oneSecPulse is a registered output, high for exactly one cycle. It asserts on the cycle after the prescaler holds CLK_FREQ_HZ-1.
- Pulse period is exactly CLK_FREQ_HZ cycles.
- The first pulse after reset comes CLK_FREQ_HZ cycles after resetN deasserts.
- Pulses continue in every FSM state, so lamp blinking still has a time base.

Counter (priority order, evaluated each clk):
1. countLoadN == 0: load {PRESET_TENS, PRESET_ONES}. This wins over any simultaneous pulse or enable.
2. Else, if countEnable && oneSecPulse && count != 00, decrement by one:
   - ones != 0: ones - 1.
   - ones == 0: ones = 9 and tens - 1.
3. Otherwise hold. Specifically:
   - count == 00 holds at 00 and never wraps to 99.
   - countEnable without a pulse holds.
   - A pulse without countEnable holds; this covers FSM pause and delay.

timerEnd:
- Combinational decode of the registered digits: (tens == 0 && ones == 0).
- It rises in the cycle after the decrement from 01 to 00.
- It stays high until a load.

Load mid-run:
- Reloads the count immediately.
- The prescaler phase is unaffected, so the first decrement after a load falls anywhere within 1..CLK_FREQ_HZ cycles.

Reset mid-operation:
- Immediate return to the reset values, including prescaler phase 0.

Digits:
- Always valid BCD 0..9; no illegal codes are reachable.
- A preset of 00 gives timerEnd high directly after a load.

Optional Feature:
Macro: BOMB_TIMER_WARN_EN.
- Defined:
  - Adds output warning = (count != 00) && (count <= WARN_SEC). The comparison uses tens*10 + ones in 7-bit arithmetic.
  - warning is combinational from the digits and is 0 at reset unless the preset itself is in range.
  - warning drops to 0 when timerEnd rises.
- Undefined:
  - The warning port and its logic are absent.
  - WARN_SEC is ignored.
  - All other behaviour is identical.

Decomposition:
Package bomb_timer_pkg holds:
- typedef logic [3:0] bcd_t
- localparam BCD_MAX = 4'd9
- localparam BCD_ZERO = 4'd0

Sub-module bcd_down_digit:
- Inputs: clk, resetN, load, loadVal (bcd_t), dec.
- Outputs: digit (bcd_t) and borrow (= dec && digit == 0).
- On load it takes loadVal; on dec it decrements, wrapping 0 to 9.
- bomb_timer instantiates two of these:
  - ones dec = countEnable && oneSecPulse && !timerEnd.
  - tens dec = ones borrow.
- The prescaler stays inline in bomb_timer.

Test Plan:
1. Pulse timing, CLK_FREQ_HZ=10, release reset: oneSecPulse at cycles 10, 20, 30, each 1 cycle wide. It keeps pulsing with countEnable=0.
2. Count-down with borrow, preset 12, countLoadN low 1 cycle, then countEnable=1: digits go 12→11→10→09→…→00 on successive pulses. timerEnd rises the cycle after 01→00, and the count holds at 00 for three further pulses.
3. Pause, preset 30, running: drop countEnable across 2 pulses and the digits stay frozen. Re-enable and the next pulse gives a decrement by exactly 1.
4. Load vs. pulse collision: countLoadN=0 in the same cycle as oneSecPulse with countEnable=1 at count 17 → count becomes 30, not 16 or 29.
5. Reset mid-run: assert resetN low at count 08 with the prescaler at 6 → count = preset and oneSecPulse = 0 immediately. The first pulse comes 10 cycles after release.
6. With BOMB_TIMER_WARN_EN and WARN_SEC=5, preset 07 run to end: warning low at 07 and 06, high at 05..01, low at 00 while timerEnd is high.

Source files
------------

// File: rtl/bomb_timer_pkg.sv
// ---------------------------------------------------------------------------
// bomb_timer_pkg
//   Shared types and constants for the bomb countdown timer slice.
//   - bcd_t    : one binary-coded-decimal digit (legal codes 0..9)
//   - BCD_MAX  : largest legal BCD digit, the wrap target of a decrement
//   - BCD_ZERO : smallest legal BCD digit
//   - bcdToBin : helper turning a two-digit BCD count into its 7-bit value
// ---------------------------------------------------------------------------
package bomb_timer_pkg;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_MAX  = 4'd9;
  localparam bcd_t BCD_ZERO = 4'd0;

  // tens*10 + ones; 99 is the largest legal input and fits in 7 bits.
  function automatic logic [6:0] bcdToBin(input bcd_t tens, input bcd_t ones);
    logic [6:0] tensBin;
    logic [6:0] onesBin;
    tensBin  = {3'b000, tens};
    onesBin  = {3'b000, ones};
    bcdToBin = (tensBin * 7'd10) + onesBin;
  endfunction

endpackage

// File: rtl/bomb_timer_if.sv
// ---------------------------------------------------------------------------
// bomb_timer_if
//   Signal bundle between the bomb control FSM and the countdown timer.
//
//   Signalling contract (no valid/ready pairs on this link): countLoadN and
//   countEnable are levels sampled on every rising clk edge; oneSecPulse is
//   a single-cycle strobe that the FSM must act on in the cycle it is high;
//   timerEnd, tensDigit, onesDigit (and warning) are levels that are valid
//   in every cycle outside reset and need no acknowledgement.
//
//   Signals:
//     countLoadN  FSM -> timer  synchronous load of the preset, active-low
//     countEnable FSM -> timer  permits a decrement on each oneSecPulse
//     oneSecPulse timer -> FSM  one-clk strobe once per CLK_FREQ_HZ cycles
//     timerEnd    timer -> FSM  high while the count is 00
//     tensDigit   timer -> FSM  BCD tens digit for the display path
//     onesDigit   timer -> FSM  BCD ones digit for the display path
//     warning     timer -> FSM  final-seconds indicator, only present when
//                               BOMB_TIMER_WARN_EN is defined
//
//   Modports: master = FSM side, slave = timer side.
// ---------------------------------------------------------------------------
interface bomb_timer_if;
  import bomb_timer_pkg::*;

  logic countLoadN;
  logic countEnable;
  logic oneSecPulse;
  logic timerEnd;
  bcd_t tensDigit;
  bcd_t onesDigit;
`ifdef BOMB_TIMER_WARN_EN
  logic warning;
`endif

`ifdef BOMB_TIMER_WARN_EN
  modport master (
    output countLoadN,
    output countEnable,
    input  oneSecPulse,
    input  timerEnd,
    input  tensDigit,
    input  onesDigit,
    input  warning
  );

  modport slave (
    input  countLoadN,
    input  countEnable,
    output oneSecPulse,
    output timerEnd,
    output tensDigit,
    output onesDigit,
    output warning
  );
`else
  modport master (
    output countLoadN,
    output countEnable,
    input  oneSecPulse,
    input  timerEnd,
    input  tensDigit,
    input  onesDigit
  );

  modport slave (
    input  countLoadN,
    input  countEnable,
    output oneSecPulse,
    output timerEnd,
    output tensDigit,
    output onesDigit
  );
`endif

endinterface

// File: rtl/bomb_timer_bcd_down_digit.sv
// ---------------------------------------------------------------------------
// bcd_down_digit
//   One BCD digit of a cascadable down-counter.
//   Load has priority over decrement; a decrement from 0 wraps to 9 and
//   raises borrow in the same cycle so the next-higher digit can follow.
//
//   Parameters:
//     RESET_VAL  digit value held while resetN is low
//   Ports:
//     clk      input   system clock, rising edge
//     resetN   input   asynchronous reset, active-low
//     load     input   synchronous load of loadVal
//     loadVal  input   BCD value taken on load
//     dec      input   decrement request for this cycle
//     digit    output  registered BCD digit
//     borrow   output  combinational: dec && digit == 0
// ---------------------------------------------------------------------------
module bcd_down_digit
  import bomb_timer_pkg::*;
#(
  parameter bcd_t RESET_VAL = BCD_ZERO
) (
  input  logic clk,
  input  logic resetN,
  input  logic load,
  input  bcd_t loadVal,
  input  logic dec,
  output bcd_t digit,
  output logic borrow
);

  bcd_t digitQ;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      digitQ <= RESET_VAL;
    end else if (load) begin
      digitQ <= loadVal;
    end else if (dec) begin
      digitQ <= (digitQ == BCD_ZERO) ? BCD_MAX : (digitQ - 4'd1);
    end
  end

  assign digit  = digitQ;
  assign borrow = dec && (digitQ == BCD_ZERO);

endmodule

// File: rtl/bomb_timer.sv
// ---------------------------------------------------------------------------
// bomb_timer
//   Countdown timer stage beside the bomb control FSM: a free-running
//   one-second prescaler plus a two-digit BCD down-counter that stops at 00.
//
//   Optional feature macro: BOMB_TIMER_WARN_EN adds the warning output,
//   high while 00 < count <= WARN_SEC.
//
//   Parameters:
//     CLK_FREQ_HZ  clk cycles per oneSecPulse period (>= 2)
//     PRESET_TENS  tens digit loaded on countLoadN (0..9)
//     PRESET_ONES  ones digit loaded on countLoadN (0..9)
//     WARN_SEC     warning threshold in seconds (1..99), warning build only
//   Ports:
//     clk     input  system clock, rising edge
//     resetN  input  asynchronous reset, active-low
//     bus     slave modport of bomb_timer_if (countLoadN, countEnable in;
//             oneSecPulse, timerEnd, tensDigit, onesDigit, [warning] out)
// ---------------------------------------------------------------------------
module bomb_timer
  import bomb_timer_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int PRESET_TENS = 3,
  parameter int PRESET_ONES = 0,
  parameter int WARN_SEC    = 5
) (
  input  logic         clk,
  input  logic         resetN,
  bomb_timer_if.slave  bus
);

  // Guard the width against degenerate tiny periods so the vector is legal.
  localparam int PRE_W = (CLK_FREQ_HZ > 1) ? $clog2(CLK_FREQ_HZ) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_FREQ_HZ - 1);

  localparam bcd_t PRESET_T = bcd_t'(PRESET_TENS);
  localparam bcd_t PRESET_O = bcd_t'(PRESET_ONES);

  // -------------------------------------------------------------------------
  // Prescaler: free-running, deliberately untouched by countLoadN and
  // countEnable so lamp blinking keeps its time base in every FSM state.
  // The pulse is registered from the terminal count, so it appears in the
  // cycle after the prescaler holds CLK_FREQ_HZ-1 (CLK_FREQ_HZ cycles after
  // reset release for the first one).
  // -------------------------------------------------------------------------
  logic [PRE_W-1:0] prescaler;
  logic             pulseQ;
  logic             atLast;

  assign atLast = (prescaler == PRE_LAST);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      prescaler <= '0;
      pulseQ    <= 1'b0;
    end else begin
      pulseQ    <= atLast;
      prescaler <= atLast ? '0 : (prescaler + PRE_W'(1));
    end
  end

  // -------------------------------------------------------------------------
  // Two-digit BCD down-counter built from cascaded digits.
  // Saturation at 00 comes from gating the ones decrement with timerEnd;
  // the tens digit only ever moves on a ones borrow.
  // -------------------------------------------------------------------------
  logic load;
  logic onesDec;
  logic onesBorrow;
  logic tensBorrow;
  logic timerEndC;
  bcd_t tens;
  bcd_t ones;

  assign load    = !bus.countLoadN;
  assign onesDec = bus.countEnable && pulseQ && !timerEndC;

  bcd_down_digit #(
    .RESET_VAL (PRESET_O)
  ) uOnes (
    .clk     (clk),
    .resetN  (resetN),
    .load    (load),
    .loadVal (PRESET_O),
    .dec     (onesDec),
    .digit   (ones),
    .borrow  (onesBorrow)
  );

  bcd_down_digit #(
    .RESET_VAL (PRESET_T)
  ) uTens (
    .clk     (clk),
    .resetN  (resetN),
    .load    (load),
    .loadVal (PRESET_T),
    .dec     (onesBorrow),
    .digit   (tens),
    .borrow  (tensBorrow)
  );

  // A tens borrow can only occur from 00, which the timerEnd gate prevents,
  // so it is intentionally left unconnected beyond this point.
  logic unusedTensBorrow;
  assign unusedTensBorrow = tensBorrow;

  assign timerEndC = (tens == BCD_ZERO) && (ones == BCD_ZERO);

  assign bus.oneSecPulse = pulseQ;
  assign bus.timerEnd    = timerEndC;
  assign bus.tensDigit   = tens;
  assign bus.onesDigit   = ones;

`ifdef BOMB_TIMER_WARN_EN
  // -------------------------------------------------------------------------
  // Final-seconds indicator: purely combinational from the digits, so it
  // falls in the same cycle timerEnd rises.
  // -------------------------------------------------------------------------
  localparam logic [6:0] WARN_LIMIT = 7'(WARN_SEC);

  logic [6:0] countBin;

  assign countBin    = bcdToBin(tens, ones);
  assign bus.warning = (countBin != 7'd0) && (countBin <= WARN_LIMIT);
`endif

endmodule

// File: tb/tb_bomb_timer.sv
// ---------------------------------------------------------------------------
// tb_bomb_timer
//   Three timer instances share clk/resetN, each with its own preset and its
//   own countLoadN/countEnable: A = 30, B = 12, C = 07 (WARN_SEC = 5),
//   all with CLK_FREQ_HZ = 10.
//   A behavioural model tracks the seconds count as a plain integer and the
//   pulse as "n > 0 and n divisible by F", where n is the number of clock
//   edges since reset release; a compare process checks every instance on
//   every falling edge. Directed sequences add hand-computed expectations.
// ---------------------------------------------------------------------------
module tb_bomb_timer;

  localparam int F = 10;

  logic clk    = 1'b0;
  logic resetN = 1'b0;
  logic ldN [3];
  logic en  [3];

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  bomb_timer_if busA ();
  bomb_timer_if busB ();
  bomb_timer_if busC ();

  assign busA.countLoadN  = ldN[0];
  assign busA.countEnable = en[0];
  assign busB.countLoadN  = ldN[1];
  assign busB.countEnable = en[1];
  assign busC.countLoadN  = ldN[2];
  assign busC.countEnable = en[2];

  bomb_timer #(.CLK_FREQ_HZ(F), .PRESET_TENS(3), .PRESET_ONES(0), .WARN_SEC(5))
    dutA (.clk(clk), .resetN(resetN), .bus(busA));
  bomb_timer #(.CLK_FREQ_HZ(F), .PRESET_TENS(1), .PRESET_ONES(2), .WARN_SEC(5))
    dutB (.clk(clk), .resetN(resetN), .bus(busB));
  bomb_timer #(.CLK_FREQ_HZ(F), .PRESET_TENS(0), .PRESET_ONES(7), .WARN_SEC(5))
    dutC (.clk(clk), .resetN(resetN), .bus(busC));

  logic       pulseW    [3];
  logic       timerEndW [3];
  logic [3:0] tensW     [3];
  logic [3:0] onesW     [3];

  assign pulseW[0] = busA.oneSecPulse;  assign timerEndW[0] = busA.timerEnd;
  assign pulseW[1] = busB.oneSecPulse;  assign timerEndW[1] = busB.timerEnd;
  assign pulseW[2] = busC.oneSecPulse;  assign timerEndW[2] = busC.timerEnd;
  assign tensW[0]  = busA.tensDigit;    assign onesW[0]     = busA.onesDigit;
  assign tensW[1]  = busB.tensDigit;    assign onesW[1]     = busB.onesDigit;
  assign tensW[2]  = busC.tensDigit;    assign onesW[2]     = busC.onesDigit;

`ifdef BOMB_TIMER_WARN_EN
  logic warnW [3];
  assign warnW[0] = busA.warning;
  assign warnW[1] = busB.warning;
  assign warnW[2] = busC.warning;
`endif

  function automatic int preOf(input int i);
    case (i)
      0:       preOf = 30;
      1:       preOf = 12;
      default: preOf = 7;
    endcase
  endfunction

  function automatic int countOf(input int i);
    countOf = int'(tensW[i]) * 10 + int'(onesW[i]);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int n = 0;
  int cnt [3] = '{30, 12, 7};

  always @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      n <= 0;
      for (int i = 0; i < 3; i++) cnt[i] <= preOf(i);
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (!ldN[i])
          cnt[i] <= preOf(i);
        else if (en[i] && (n > 0) && (n % F == 0) && (cnt[i] != 0))
          cnt[i] <= cnt[i] - 1;
      end
      n <= n + 1;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("pulse[%0d]", i), int'(pulseW[i]), int'((n > 0) && (n % F == 0)));
      chk($sformatf("tens[%0d]", i), int'(tensW[i]), cnt[i] / 10);
      chk($sformatf("ones[%0d]", i), int'(onesW[i]), cnt[i] % 10);
      chk($sformatf("timerEnd[%0d]", i), int'(timerEndW[i]), int'(cnt[i] == 0));
`ifdef BOMB_TIMER_WARN_EN
      chk($sformatf("warning[%0d]", i), int'(warnW[i]), int'((cnt[i] != 0) && (cnt[i] <= 5)));
`endif
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Advance until a pulse is visible (the next edge consumes it).
  task automatic wait_pulse();
    int k;
    k = 0;
    while (!pulseW[0] && k < 2 * F) begin
      tick();
      k++;
    end
    if (!pulseW[0]) chk("pulse_timeout", 0, 1);
  endtask

  task automatic next_sec();
    wait_pulse();
    tick();
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int c;
    int first;
    for (int i = 0; i < 3; i++) begin
      ldN[i] = 1'b1;
      en[i]  = 1'b0;
    end
    resetN = 1'b0;
    repeat (3) @(negedge clk);

    // Reset values.
    chk("rst_A_count", countOf(0), 30);
    chk("rst_B_count", countOf(1), 12);
    chk("rst_C_count", countOf(2), 7);
    chk("rst_A_pulse", int'(pulseW[0]), 0);
    chk("rst_A_timerEnd", int'(timerEndW[0]), 0);
`ifdef BOMB_TIMER_WARN_EN
    chk("rst_C_warning", int'(warnW[2]), 0);
`endif

    // 1: pulse timing with countEnable low everywhere.
    resetN = 1'b1;
    for (int k = 1; k <= 35; k++) begin
      tick();
      chk($sformatf("t1_pulse_cyc%0d", k), int'(pulseW[0]),
          int'(k == 10 || k == 20 || k == 30));
    end
    chk("t1_A_hold", countOf(0), 30);

    // 2 and 6: B counts 12 -> 00, C counts 07 -> 00.
    ldN[1] = 1'b0;
    ldN[2] = 1'b0;
    tick();
    ldN[1] = 1'b1;
    ldN[2] = 1'b1;
    en[1]  = 1'b1;
    en[2]  = 1'b1;
    chk("t2_B_loaded", countOf(1), 12);
    for (int s = 1; s <= 15; s++) begin
      next_sec();
      c = (12 - s > 0) ? 12 - s : 0;
      chk($sformatf("t2_B_sec%0d", s), countOf(1), c);
      chk($sformatf("t2_B_end_sec%0d", s), int'(timerEndW[1]), int'(s >= 12));
      c = (7 - s > 0) ? 7 - s : 0;
      chk($sformatf("t6_C_sec%0d", s), countOf(2), c);
`ifdef BOMB_TIMER_WARN_EN
      chk($sformatf("t6_C_warn_sec%0d", s), int'(warnW[2]), int'(s >= 2 && s <= 6));
`endif
    end

    // 3: pause on A.
    ldN[0] = 1'b0;
    tick();
    ldN[0] = 1'b1;
    en[0]  = 1'b1;
    chk("t3_A_loaded", countOf(0), 30);
    repeat (2) next_sec();
    chk("t3_A_run", countOf(0), 28);
    en[0] = 1'b0;
    repeat (2) next_sec();
    chk("t3_A_paused", countOf(0), 28);
    en[0] = 1'b1;
    next_sec();
    chk("t3_A_resume", countOf(0), 27);
    repeat (10) next_sec();
    chk("t3_A_17", countOf(0), 17);

    // 4: load collides with an enabled pulse at 17.
    wait_pulse();
    ldN[0] = 1'b0;
    tick();
    ldN[0] = 1'b1;
    chk("t4_A_collide", countOf(0), 30);

    // 5: reset at count 08 with prescaler at 6.
    repeat (22) next_sec();
    chk("t5_A_08", countOf(0), 8);
    repeat (5) tick();
    #2 resetN = 1'b0;
    #1;
    chk("t5_A_rst_count", countOf(0), 30);
    chk("t5_A_rst_pulse", int'(pulseW[0]), 0);
    chk("t5_B_rst_count", countOf(1), 12);
    @(negedge clk);
    resetN = 1'b1;
    first = 0;
    for (int k = 1; k <= 2 * F; k++) begin
      tick();
      if (pulseW[0] && first == 0) first = k;
    end
    chk("t5_first_pulse_cyc", first, 10);

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
